// File: rtl/uart_pkg.sv
// Shared UART definitions: line-state and parity encodings used by the TX and RX cores.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    typedef enum logic [1:0] {
        PAR_NONE  = 2'b00,
        PAR_EVEN  = 2'b01,
        PAR_ODD   = 2'b10,
        PAR_NONE2 = 2'b11
    } uart_parity_e;

    function automatic logic parity_enabled(input logic [1:0] p);
        return (p == PAR_EVEN) || (p == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with async reset; dout shows the head entry (first-word latency 1).
// Compiled only when UART_TX_FIFO_EN is defined, the only build that instantiates it.
`ifdef UART_TX_FIFO_EN
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             push_ok, pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign level   = count;
    assign dout    = mem[rd_ptr];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop_ok)      count <= count + 1'b1;
            else if (!push_ok && pop_ok) count <= count - 1'b1;
        end
    end
endmodule
`endif

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter (1..WIDTH data bits, optional parity, 1/2 stop bits).
// Define UART_TX_FIFO_EN to place a FIFO_DEPTH-entry uart_fifo between the handshake and the core.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          s_tick,
    input  logic                          tx_valid,
    input  logic [WIDTH-1:0]              din,
    output logic                          tx_ready,
    input  logic [$clog2(WIDTH):0]        cfg_nbits,
    input  logic [1:0]                    cfg_parity,
    input  logic                          cfg_stop2,
    output logic                          tx,
    output logic                          tx_busy,
    output logic                          tx_done_tick,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int NW = $clog2(WIDTH) + 1;
    localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

    uart_state_e      state, state_n;
    logic [TW-1:0]    tick_cnt;
    logic [NW-1:0]    bit_cnt, nbits_q, nbits_eff;
    logic [WIDTH-1:0] shreg, word, mask;
    logic             par_en_q, par_bit_q, stop2_q, stop_half;
    logic             tick_last, word_avail;

`ifdef UART_TX_FIFO_EN
    logic fifo_empty, fifo_full;

    assign word_avail = (state == ST_IDLE) && !fifo_empty;
    assign tx_ready   = !fifo_full;

    uart_fifo #(.WIDTH(WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_valid && tx_ready),
        .din   (din),
        .pop   (word_avail),
        .dout  (word),
        .empty (fifo_empty),
        .full  (fifo_full),
        .level (fifo_level)
    );
`else
    assign tx_ready   = (state == ST_IDLE);
    assign word_avail = tx_valid && tx_ready;
    assign word       = din;
    assign fifo_level = '0;
`endif

    // Out-of-range bit counts fall back to a full-width frame; mask drops unused upper bits.
    always_comb begin
        nbits_eff = cfg_nbits;
        if (cfg_nbits == '0 || cfg_nbits > NW'(WIDTH)) nbits_eff = NW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) mask[i] = (i < int'(nbits_eff));
    end

    assign tick_last = s_tick && (tick_cnt == TW'(OVERSAMPLE - 1));
    assign tx_busy   = (state != ST_IDLE);

    always_comb begin
        state_n      = state;
        tx_done_tick = 1'b0;
        case (state)
            ST_IDLE:   if (word_avail) state_n = ST_START;
            ST_START:  if (tick_last) state_n = ST_DATA;
            ST_DATA:   if (tick_last && bit_cnt == nbits_q - 1'b1)
                           state_n = par_en_q ? ST_PARITY : ST_STOP;
            ST_PARITY: if (tick_last) state_n = ST_STOP;
            ST_STOP:   if (tick_last && (!stop2_q || stop_half)) begin
                           state_n      = ST_IDLE;
                           tx_done_tick = 1'b1;
                       end
            default:   state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            nbits_q   <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
            stop_half <= 1'b0;
            tx        <= 1'b1;
        end else begin
            state <= state_n;
            // tx is a registered image of the current state, so it trails the state by one clk
            case (state)
                ST_START:  tx <= 1'b0;
                ST_DATA:   tx <= shreg[0];
                ST_PARITY: tx <= par_bit_q;
                default:   tx <= 1'b1;
            endcase
            if (state == ST_IDLE) begin
                tick_cnt <= '0;
                if (word_avail) begin
                    shreg     <= word & mask;
                    nbits_q   <= nbits_eff;
                    par_en_q  <= parity_enabled(cfg_parity);
                    par_bit_q <= (^(word & mask)) ^ (cfg_parity == PAR_ODD);
                    stop2_q   <= cfg_stop2;
                    bit_cnt   <= '0;
                    stop_half <= 1'b0;
                end
            end else if (s_tick) begin
                tick_cnt <= tick_last ? '0 : tick_cnt + 1'b1;
                if (tick_last && state == ST_DATA) begin
                    shreg   <= shreg >> 1;
                    bit_cnt <= bit_cnt + 1'b1;
                end
                if (tick_last && state == ST_STOP) stop_half <= ~stop_half;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: table + random frames decoded by a behavioural UART receiver model.
module tb_uart_tx_cfg;
    localparam int BIT_CLK = 64;   // 16 ticks x 4 clk
`ifdef UART_TX_FIFO_EN
    localparam int LAT = 1;
    localparam int K   = 6;
`else
    localparam int LAT = 0;
    localparam int K   = 3;
`endif

    logic       clk = 1'b0, rst = 1'b1, tx_valid = 1'b0, cfg_stop2 = 1'b0;
    logic [7:0] din = 8'h00;
    logic [3:0] cfg_nbits = 4'd8;
    logic [1:0] cfg_parity = 2'b00;
    logic       s_tick, tx_ready, tx, tx_busy, tx_done_tick;
    logic [2:0] fifo_level;
    bit         tick_en = 1'b1;
    int unsigned cyc = 0;

    int   checks = 0, errors = 0;
    logic rec[$];
    bit   exp_q[$];

    uart_tx_cfg #(.WIDTH(8), .OVERSAMPLE(16), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .s_tick(s_tick), .tx_valid(tx_valid), .din(din),
        .tx_ready(tx_ready), .cfg_nbits(cfg_nbits), .cfg_parity(cfg_parity),
        .cfg_stop2(cfg_stop2), .tx(tx), .tx_busy(tx_busy), .tx_done_tick(tx_done_tick),
        .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign s_tick = tick_en && (cyc[1:0] == 2'd3);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Expected line levels of one frame, one entry per bit period.
    function automatic void build_exp(input logic [7:0] d, input int nb_cfg,
                                      input logic [1:0] par, input bit st2);
        int nb, ones;
        exp_q.delete();
        nb   = (nb_cfg == 0 || nb_cfg > 8) ? 8 : nb_cfg;
        ones = 0;
        exp_q.push_back(1'b0);
        for (int i = 0; i < nb; i++) begin
            exp_q.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (par == 2'b01) exp_q.push_back(bit'(ones % 2));
        if (par == 2'b10) exp_q.push_back(bit'(1 - ones % 2));
        exp_q.push_back(1'b1);
        if (st2) exp_q.push_back(1'b1);
    endfunction

    function automatic logic [31:0] pack_exp();
        logic [31:0] v = '0;
        foreach (exp_q[i]) v[i] = exp_q[i];
        return v;
    endfunction

    function automatic int find_fall(input int from);
        for (int i = from; i < rec.size(); i++)
            if (rec[i] === 1'b0 && (i == 0 || rec[i-1] !== 1'b0)) return i;
        return -1;
    endfunction

    // Receiver model: sample the middle of each bit period after the falling edge.
    function automatic logic [31:0] decode(input int f, input int n);
        logic [31:0] v = '0;
        int idx;
        for (int k = 0; k < n; k++) begin
            idx  = f + BIT_CLK/2 + BIT_CLK*k;
            v[k] = (f >= 0 && idx < rec.size()) ? rec[idx] : 1'bx;
        end
        return v;
    endfunction

    // Handshake timed so the latch edge coincides with a tick; returns #1 after the latch edge.
    task automatic align_and_send(input logic [7:0] d, input int nb, input logic [1:0] par, input bit st2);
        cfg_nbits = 4'(nb); cfg_parity = par; cfg_stop2 = st2; din = d;
        do begin @(posedge clk); #1; end while (cyc[1:0] != 2'(3 - LAT));
        tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        repeat (LAT) begin @(posedge clk); #1; end
    endtask

    task automatic run_frame(input string name, input logic [7:0] d, input int nb, input logic [1:0] par,
                             input bit st2, input int exp_bits, input logic exp_pb, input bit perturb);
        int n, f, nd, didx, busy_cnt;
        logic [31:0] got;
        build_exp(d, nb, par, st2);
        n = exp_q.size();
        rec.delete(); nd = 0; didx = -1; busy_cnt = 0;
        align_and_send(d, nb, par, st2);
        for (int s = 0; s < BIT_CLK*exp_bits + 6; s++) begin
            rec.push_back(tx);
            if (tx_busy) busy_cnt++;
            if (tx_done_tick) begin nd++; didx = s; end
            if (perturb && s == BIT_CLK*3) begin
                cfg_parity = ~par; cfg_stop2 = ~st2; cfg_nbits = 4'd3; din = ~d;
            end
            @(posedge clk); #1;
        end
        cfg_parity = par; cfg_stop2 = st2; cfg_nbits = 4'(nb);
        f   = find_fall(0);
        got = decode(f, n);
        chk({name, ":fall"}, f, 1);
        chk({name, ":bits"}, got, pack_exp());
        chk({name, ":busy"}, busy_cnt, BIT_CLK*exp_bits);
        chk({name, ":ndone"}, nd, 1);
        chk({name, ":done_at"}, didx, BIT_CLK*exp_bits - 1);
        if (par == 2'b01 || par == 2'b10)
            chk({name, ":parity"}, got[n - 1 - (st2 ? 2 : 1)], exp_pb);
    endtask

    typedef struct {
        string      name;
        logic [7:0] d;
        int         nb;
        logic [1:0] par;
        bit         st2;
        int         exp_bits;
        logic       exp_pb;
    } vec_t;

    vec_t vecs[$];

    initial begin
        #5ms;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int tlim, lowc, donec, nxt, lvl, lvl_err, dn_now;
        bit core_idle, hs, pop_m, full_chk;
        int push_idx[$], dones[$], f, pos;
        logic [7:0] w[$];
        logic [7:0] rd;
        int rnb, n;
        logic [1:0] rpar;
        bit rst2;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst:tx", tx, 1);
        chk("rst:busy", tx_busy, 0);
        chk("rst:done", tx_done_tick, 0);
        chk("rst:ready", tx_ready, 1);
        chk("rst:level", fifo_level, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst:tx", tx, 1);

        vecs = '{
            '{"8N1_A5",   8'hA5,  8, 2'b00, 1'b0, 10, 1'b0},
            '{"7E2_35",   8'h35,  7, 2'b01, 1'b1, 11, 1'b0},
            '{"5O1_FF",   8'hFF,  5, 2'b10, 1'b0,  8, 1'b0},
            '{"nb0_3C",   8'h3C,  0, 2'b00, 1'b0, 10, 1'b0},
            '{"nb12_81",  8'h81, 12, 2'b11, 1'b1, 11, 1'b0},
            '{"1E1_01",   8'h01,  1, 2'b01, 1'b0,  4, 1'b1},
            '{"1O2_02",   8'h02,  1, 2'b10, 1'b1,  5, 1'b1},
            '{"8O1_C3",   8'hC3,  8, 2'b10, 1'b0, 11, 1'b1}
        };
        foreach (vecs[i])
            run_frame(vecs[i].name, vecs[i].d, vecs[i].nb, vecs[i].par, vecs[i].st2,
                      vecs[i].exp_bits, vecs[i].exp_pb, 1'b0);

        // configuration changes during DATA must not affect the frame in flight
        run_frame("cfgchg_7E2", 8'h35, 7, 2'b01, 1'b1, 11, 1'b0, 1'b1);

        for (int r = 0; r < 16; r++) begin
            rd   = 8'($urandom);
            rnb  = int'($urandom_range(0, 15));
            rpar = 2'($urandom_range(0, 3));
            rst2 = bit'($urandom_range(0, 1));
            build_exp(rd, rnb, rpar, rst2);
            n = exp_q.size();
            run_frame($sformatf("rand%0d", r), rd, rnb, rpar, rst2, n, exp_q[n - 1 - (rst2 ? 2 : 1)], 1'b0);
        end

        // reset in the middle of data bit 3
        align_and_send(8'h00, 8, 2'b00, 1'b0);
        repeat (BIT_CLK*4 + 20) @(posedge clk);
        #1;
        chk("midrst:pre_tx", tx, 0);
        rst = 1'b1;
        #1;
        chk("midrst:tx", tx, 1);
        chk("midrst:busy", tx_busy, 0);
        chk("midrst:done", tx_done_tick, 0);
        chk("midrst:ready", tx_ready, 1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        lowc = 0; donec = 0;
        for (int s = 0; s < 100; s++) begin
            @(posedge clk); #1;
            if (tx !== 1'b1) lowc++;
            if (tx_done_tick) donec++;
        end
        chk("midrst:idle_low", lowc, 0);
        chk("midrst:no_done", donec, 0);
        run_frame("after_rst_0F", 8'h0F, 8, 2'b00, 1'b0, 10, 1'b0, 1'b0);

        // without s_tick the frame holds in START
        tick_en = 1'b0;
        cfg_nbits = 4'd8; cfg_parity = 2'b00; cfg_stop2 = 1'b0; din = 8'h55;
        tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        chk("notick:busy", tx_busy, 1);
        chk("notick:tx", tx, 0);
        chk("notick:level", fifo_level, 0);
        tick_en = 1'b1;
        tlim = 0;
        while (tx_busy && tlim < 2000) begin @(posedge clk); #1; tlim++; end
        chk("notick:finished", tx_busy, 0);
        repeat (10) @(posedge clk);
        #1;

        // back-to-back stream with tx_valid held high
        for (int j = 0; j < K; j++) w.push_back(8'($urandom));
        rec.delete();
        nxt = 0; lvl = 0; lvl_err = 0; core_idle = 1'b1; full_chk = 1'b0;
        din = w[0]; tx_valid = 1'b1;
        for (int s = 0; s < K*(BIT_CLK*10 + 1) + 200; s++) begin
            hs     = tx_valid && tx_ready;
            pop_m  = core_idle && (lvl > 0);
            dn_now = int'(tx_done_tick);
            @(posedge clk); #1;
`ifdef UART_TX_FIFO_EN
            if (pop_m) core_idle = 1'b0;
            if (dn_now != 0) core_idle = 1'b1;
            lvl = lvl + int'(hs) - int'(pop_m);
`endif
            if (hs) begin
                push_idx.push_back(s);
                nxt++;
                if (nxt < K) din = w[nxt];
                else tx_valid = 1'b0;
            end
            rec.push_back(tx);
            if (tx_done_tick) dones.push_back(s);
            if (int'(fifo_level) != lvl) lvl_err++;
`ifdef UART_TX_FIFO_EN
            if (push_idx.size() == 5 && !full_chk) begin
                full_chk = 1'b1;
                chk("fifo:full_ready", tx_ready, 0);
                chk("fifo:full_level", fifo_level, 4);
            end
`endif
        end
        tx_valid = 1'b0;
        chk("stream:level_track", lvl_err, 0);
        chk("stream:ndone", dones.size(), K);
        chk("stream:npush", push_idx.size(), K);
        pos = 0;
        for (int j = 0; j < K; j++) begin
            f = find_fall(pos);
            build_exp(w[j], 8, 2'b00, 1'b0);
            chk($sformatf("stream:frame%0d", j), decode(f, 10), pack_exp());
            if (j > 0 && dones.size() >= j)
                chk($sformatf("stream:gap%0d", j), f - dones[j-1], 3);
            if (f >= 0) pos = f + BIT_CLK*9 + BIT_CLK/2;
        end
        if (dones.size() > 0 && push_idx.size() == K)
`ifdef UART_TX_FIFO_EN
            chk("fifo:held_push", push_idx[5], dones[0] + 3);
`else
            chk("b2b:second_hs", push_idx[1], dones[0] + 2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
